// File: rtl/sa_bitserial_mac_pkg.sv
// Shared types and helpers for the bit-serial subarray MAC: FSM state encoding,
// accumulator width derivation and the ADC code clamp.
package sa_bitserial_mac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Widest per-column sum is (2**bit_adc-1)*(2**in_prec-1), which fits in bit_adc+in_prec bits.
    function automatic int acc_width(input int bit_adc, input int in_prec);
        return bit_adc + in_prec;
    endfunction

    function automatic int unsigned clamp_code(input int unsigned pop, input int unsigned max_code);
        return (pop > max_code) ? max_code : pop;
    endfunction

endpackage

// File: rtl/sa_bitserial_mac_if.sv
// Bus bundle for sa_bitserial_mac: weight write port, activation in, accumulator out, status.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid, once raised by the producer, holds its payload until that edge.
interface sa_bitserial_mac_if
    import sa_bitserial_mac_pkg::*;
#(
    parameter int nSaRows        = 64,
    parameter int nSaCols        = 64,
    parameter int inputPrecision = 4,
    parameter int accW           = 8
) ();

    logic                              wr_en_i;
    logic [$clog2(nSaRows)-1:0]        wr_row_i;
    logic [nSaCols-1:0]                wr_data_i;
    logic                              in_valid_i;
    logic                              in_ready_o;
    logic [nSaRows*inputPrecision-1:0] act_i;
    logic                              out_valid_o;
    logic                              out_ready_i;
    logic [nSaCols*accW-1:0]           acc_o;
    logic                              busy_o;
    state_t                            dbg_state_o;

    modport master (
        output wr_en_i, wr_row_i, wr_data_i, in_valid_i, act_i, out_ready_i,
        input  in_ready_o, out_valid_o, acc_o, busy_o, dbg_state_o
    );

    modport slave (
        input  wr_en_i, wr_row_i, wr_data_i, in_valid_i, act_i, out_ready_i,
        output in_ready_o, out_valid_o, acc_o, busy_o, dbg_state_o
    );

endinterface

// File: rtl/sa_bitserial_mac_col_adc.sv
// One shared column ADC: AND the selected weight column with the current activation bit-plane,
// popcount the matches and clamp to the ADC full-scale code.
module sa_col_adc
    import sa_bitserial_mac_pkg::*;
#(
    parameter int nSaRows = 64,
    parameter int bitAdc  = 4
) (
    input  logic [nSaRows-1:0] w_col_i,
    input  logic [nSaRows-1:0] act_bit_i,
    output logic [bitAdc-1:0]  code_o
);

    localparam int          POP_W    = $clog2(nSaRows + 1);
    localparam int unsigned CODE_MAX = (1 << bitAdc) - 1;

    logic [nSaRows-1:0] hits;
    logic [POP_W-1:0]   pop;

    always_comb begin
        hits = w_col_i & act_bit_i;
        pop  = '0;
        for (int r = 0; r < nSaRows; r++) begin
            pop = pop + POP_W'(hits[r]);
        end
        code_o = bitAdc'(clamp_code(32'(pop), CODE_MAX));
    end

endmodule

// File: rtl/sa_bitserial_mac.sv
// Bit-serial subarray MAC: binary weight array, LSB-first activation bit-planes, colMux columns
// time-sharing each ADC, and per-column shift-add accumulators behind valid/ready handshakes.
module sa_bitserial_mac
    import sa_bitserial_mac_pkg::*;
#(
    parameter int nSaRows        = 64,
    parameter int nSaCols        = 64,
    parameter int bitAdc         = 4,
    parameter int inputPrecision = 4,
    parameter int colMux         = 4
) (
    input  logic              clk,
    input  logic              rst,
    sa_bitserial_mac_if.slave bus
);

    localparam int accW  = acc_width(bitAdc, inputPrecision);
    localparam int nAdc  = nSaCols / colMux;
    localparam int ACT_W = nSaRows * inputPrecision;
    localparam int BIT_W = (inputPrecision > 1) ? $clog2(inputPrecision) : 1;
    localparam int PH_W  = (colMux > 1) ? $clog2(colMux) : 1;

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [ACT_W-1:0]   act_q, act_d;
    logic [nSaCols-1:0] w_q [nSaRows];
    logic [nSaCols-1:0] w_d [nSaRows];
    logic [accW-1:0]    acc_q [nSaCols];
    logic [accW-1:0]    acc_d [nSaCols];

    logic               accept;
    logic               last_step;
    logic [nSaRows-1:0] act_bit;
    logic [bitAdc-1:0]  code [nAdc];

    // Current activation bit-plane across all rows; act is packed [row][bit].
    always_comb begin
        act_bit = '0;
        for (int r = 0; r < nSaRows; r++) begin
            act_bit[r] = act_q[r*inputPrecision + int'(bit_q)];
        end
    end

    // ADC k serves columns k*colMux .. k*colMux+colMux-1, one per phase.
    for (genvar k = 0; k < nAdc; k++) begin : g_adc
        logic [nSaRows-1:0] w_col;

        always_comb begin
            w_col = '0;
            for (int r = 0; r < nSaRows; r++) begin
                w_col[r] = w_q[r][k*colMux + int'(ph_q)];
            end
        end

        sa_col_adc #(
            .nSaRows (nSaRows),
            .bitAdc  (bitAdc)
        ) u_adc (
            .w_col_i   (w_col),
            .act_bit_i (act_bit),
            .code_o    (code[k])
        );
    end

    assign accept    = (state_q == IDLE) && bus.in_valid_i;
    assign last_step = (bit_q == BIT_W'(inputPrecision - 1)) && (ph_q == PH_W'(colMux - 1));

    always_comb begin
        int col;
        col     = 0;
        state_d = state_q;
        bit_d   = bit_q;
        ph_d    = ph_q;
        act_d   = act_q;
        w_d     = w_q;
        acc_d   = acc_q;

        // A write coinciding with acceptance lands before the first compute cycle reads the array.
        if ((state_q == IDLE) && bus.wr_en_i) begin
            w_d[bus.wr_row_i] = bus.wr_data_i;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    act_d   = bus.act_i;
                    bit_d   = '0;
                    ph_d    = '0;
                    acc_d   = '{default: '0};
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                for (int k = 0; k < nAdc; k++) begin
                    col        = k*colMux + int'(ph_q);
                    acc_d[col] = acc_q[col] + (accW'(code[k]) << bit_q);
                end
                if (ph_q == PH_W'(colMux - 1)) begin
                    ph_d  = '0;
                    bit_d = last_step ? '0 : bit_q + 1'b1;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            ph_q    <= '0;
            act_q   <= '0;
            w_q     <= '{default: '0};
            acc_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
            act_q   <= act_d;
            w_q     <= w_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        bus.in_ready_o  = (state_q == IDLE);
        bus.out_valid_o = (state_q == DONE);
        bus.busy_o      = (state_q == COMPUTE);
        bus.dbg_state_o = state_q;
        bus.acc_o       = '0;
        for (int c = 0; c < nSaCols; c++) begin
            bus.acc_o[c*accW +: accW] = acc_q[c];
        end
    end

endmodule

// File: tb/tb_sa_bitserial_mac.sv
// Self-checking bench for sa_bitserial_mac: a behavioural weight model produces expected
// accumulator vectors that are queued at acceptance and compared when out_valid_o is seen.
module tb_sa_bitserial_mac;
    import sa_bitserial_mac_pkg::*;

    localparam int N_ROWS = 64;
    localparam int N_COLS = 64;
    localparam int BIT_ADC = 4;
    localparam int IP = 4;
    localparam int COLMUX = 4;
    localparam int ACC_W = BIT_ADC + IP;
    localparam int ACT_W = N_ROWS * IP;
    localparam int ACCV = N_COLS * ACC_W;
    localparam int LAT = IP * COLMUX;
    localparam int CODE_MAX = (1 << BIT_ADC) - 1;

    logic clk;
    logic rst;
    int cmp_cnt;
    int err_cnt;

    logic [N_COLS-1:0] model_w [N_ROWS];
    logic [ACCV-1:0] exp_q [$];

    sa_bitserial_mac_if #(
        .nSaRows(N_ROWS), .nSaCols(N_COLS), .inputPrecision(IP), .accW(ACC_W)
    ) bus ();

    sa_bitserial_mac #(
        .nSaRows(N_ROWS), .nSaCols(N_COLS), .bitAdc(BIT_ADC),
        .inputPrecision(IP), .colMux(COLMUX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [ACCV-1:0] ref_acc(input logic [ACT_W-1:0] a);
        logic [ACCV-1:0] r;
        int pop;
        int code;
        int sum;
        r = '0;
        for (int c = 0; c < N_COLS; c++) begin
            sum = 0;
            for (int b = 0; b < IP; b++) begin
                pop = 0;
                for (int row = 0; row < N_ROWS; row++) begin
                    if (a[row*IP + b] && model_w[row][c]) pop++;
                end
                code = (pop > CODE_MAX) ? CODE_MAX : pop;
                sum += code << b;
            end
            r[c*ACC_W +: ACC_W] = ACC_W'(sum);
        end
        return r;
    endfunction

    function automatic logic [ACT_W-1:0] rand_act();
        logic [ACT_W-1:0] a;
        for (int i = 0; i < ACT_W/32; i++) a[i*32 +: 32] = $urandom;
        return a;
    endfunction

    function automatic logic [N_COLS-1:0] rand_row();
        return {$urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic write_row(input int r, input logic [N_COLS-1:0] data);
        @(negedge clk);
        bus.wr_en_i   = 1'b1;
        bus.wr_row_i  = 6'(r);
        bus.wr_data_i = data;
        @(posedge clk);
        model_w[r] = data;
        #1 bus.wr_en_i = 1'b0;
    endtask

    task automatic issue(input logic [ACT_W-1:0] a);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.act_i      = a;
        bus.in_valid_i = 1'b1;
        while (!bus.in_ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        exp_q.push_back(ref_acc(a));
        @(negedge clk);
        bus.in_valid_i = 1'b0;
    endtask

    // Returns at the negedge where out_valid_o is seen (or when the budget runs out).
    task automatic wait_done(output int n, output int busy_cycles);
        n = 0;
        busy_cycles = 0;
        while (n < 200) begin
            if (bus.out_valid_o) break;
            if (bus.busy_o) busy_cycles++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        int stale;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_flags: ready=%b valid=%b busy=%b, required 1 0 0",
                     bus.in_ready_o, bus.out_valid_o, bus.busy_o);
        end
        cmp_cnt++;
        if (bus.acc_o !== '0) begin
            err_cnt++;
            $display("FAIL reset_acc: acc_o=%h, required 0", bus.acc_o);
        end
        rst = 1'b0;

        for (int r = 0; r < 4; r++) write_row(r, '1);
        issue('1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int r = 0; r < N_ROWS; r++) model_w[r] = '0;
        cmp_cnt++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mid_flags: ready=%b valid=%b busy=%b, required 1 0 0",
                     bus.in_ready_o, bus.out_valid_o, bus.busy_o);
        end
        cmp_cnt++;
        if (bus.acc_o !== '0) begin
            err_cnt++;
            $display("FAIL reset_mid_acc: acc_o=%h, required 0", bus.acc_o);
        end
        stale = 0;
        for (n = 0; n < 2*LAT; n++) begin
            @(negedge clk);
            if (bus.out_valid_o !== 1'b0) stale++;
        end
        cmp_cnt++;
        if (stale != 0) begin
            err_cnt++;
            $display("FAIL reset_stale_done: out_valid high in %0d cycles, required 0", stale);
        end
    endtask

    task automatic test_all_ones();
        int n, bc;
        logic [ACCV-1:0] exp;
        logic [ACCV-1:0] const_exp;
        for (int r = 0; r < N_ROWS; r++) write_row(r, '1);
        issue('1);
        wait_done(n, bc);
        cmp_cnt++;
        if (bus.out_valid_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL all_ones_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid_o, n);
        end
        exp = exp_q.pop_front();
        cmp_cnt++;
        if (bus.acc_o !== exp) begin
            err_cnt++;
            $display("FAIL all_ones_acc: got %h required %h", bus.acc_o, exp);
        end
        for (int c = 0; c < N_COLS; c++) const_exp[c*ACC_W +: ACC_W] = 8'd225;
        cmp_cnt++;
        if (bus.acc_o !== const_exp) begin
            err_cnt++;
            $display("FAIL all_ones_225: got %h required %h", bus.acc_o, const_exp);
        end
        take();
    endtask

    task automatic test_sparse_col0();
        int n, bc;
        logic [ACT_W-1:0] a;
        logic [ACCV-1:0] exp;
        logic [ACCV-1:0] const_exp;
        for (int r = 0; r < N_ROWS; r++) write_row(r, (r < 3) ? 64'h1 : 64'h0);
        a = '0;
        for (int r = 0; r < 3; r++) a[r*IP +: IP] = 4'h5;
        issue(a);
        wait_done(n, bc);
        cmp_cnt++;
        if (bus.out_valid_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL sparse_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid_o, n);
        end
        exp = exp_q.pop_front();
        cmp_cnt++;
        if (bus.acc_o !== exp) begin
            err_cnt++;
            $display("FAIL sparse_acc: got %h required %h", bus.acc_o, exp);
        end
        const_exp = '0;
        const_exp[ACC_W-1:0] = 8'd15;
        cmp_cnt++;
        if (bus.acc_o !== const_exp) begin
            err_cnt++;
            $display("FAIL sparse_col0_15: got %h required %h", bus.acc_o, const_exp);
        end
        take();
    endtask

    task automatic test_latency();
        int n, bc;
        logic [ACCV-1:0] exp;
        for (int r = 0; r < 8; r++) write_row(r, rand_row());
        issue(rand_act());
        wait_done(n, bc);
        cmp_cnt++;
        if (n != LAT) begin
            err_cnt++;
            $display("FAIL latency: out_valid after %0d cycles, required %0d", n, LAT);
        end
        cmp_cnt++;
        if (bc != LAT) begin
            err_cnt++;
            $display("FAIL busy_len: busy high %0d cycles, required %0d", bc, LAT);
        end
        cmp_cnt++;
        if (bus.busy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL busy_in_done: busy=%b, required 0", bus.busy_o);
        end
        exp = exp_q.pop_front();
        cmp_cnt++;
        if (bus.acc_o !== exp) begin
            err_cnt++;
            $display("FAIL latency_acc: got %h required %h", bus.acc_o, exp);
        end
        take();
    endtask

    task automatic test_backpressure();
        int n, bc;
        int bad_acc, bad_rdy;
        logic [ACT_W-1:0] a2;
        logic [ACCV-1:0] e1;
        logic [ACCV-1:0] e2;
        issue(rand_act());
        wait_done(n, bc);
        e1 = exp_q.pop_front();
        cmp_cnt++;
        if (bus.out_valid_o !== 1'b1 || bus.acc_o !== e1) begin
            err_cnt++;
            $display("FAIL bp_first: valid=%b acc=%h required 1 %h", bus.out_valid_o, bus.acc_o, e1);
        end
        a2 = rand_act();
        bus.act_i = a2;
        bus.in_valid_i = 1'b1;
        bus.out_ready_i = 1'b0;
        bad_acc = 0;
        bad_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.acc_o !== e1 || bus.out_valid_o !== 1'b1) bad_acc++;
            if (bus.in_ready_o !== 1'b0) bad_rdy++;
        end
        cmp_cnt++;
        if (bad_acc != 0) begin
            err_cnt++;
            $display("FAIL bp_hold: acc/valid changed in %0d cycles, required 0", bad_acc);
        end
        cmp_cnt++;
        if (bad_rdy != 0) begin
            err_cnt++;
            $display("FAIL bp_ready: in_ready high in %0d DONE cycles, required 0", bad_rdy);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        cmp_cnt++;
        if (bus.dbg_state_o !== IDLE || bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_release: state=%0d ready=%b valid=%b, required IDLE 1 0",
                     bus.dbg_state_o, bus.in_ready_o, bus.out_valid_o);
        end
        cmp_cnt++;
        if (bus.acc_o !== e1) begin
            err_cnt++;
            $display("FAIL bp_acc_kept: got %h required %h", bus.acc_o, e1);
        end
        @(posedge clk);
        exp_q.push_back(ref_acc(a2));
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        cmp_cnt++;
        if (bus.busy_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_next_accept: busy=%b, required 1", bus.busy_o);
        end
        wait_done(n, bc);
        e2 = exp_q.pop_front();
        cmp_cnt++;
        if (bus.out_valid_o !== 1'b1 || bus.acc_o !== e2) begin
            err_cnt++;
            $display("FAIL bp_second: valid=%b acc=%h required 1 %h", bus.out_valid_o, bus.acc_o, e2);
        end
        take();
    endtask

    task automatic test_write_during_compute();
        int n, bc;
        logic [ACCV-1:0] exp;
        for (int r = 0; r < N_ROWS; r++) write_row(r, rand_row());
        issue(rand_act());
        for (int i = 0; i < 3; i++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_row_i  = 6'(i);
            bus.wr_data_i = ~model_w[i];
            @(negedge clk);
        end
        bus.wr_en_i = 1'b0;
        wait_done(n, bc);
        exp = exp_q.pop_front();
        cmp_cnt++;
        if (bus.out_valid_o !== 1'b1 || bus.acc_o !== exp) begin
            err_cnt++;
            $display("FAIL wr_in_compute: valid=%b acc=%h required 1 %h", bus.out_valid_o, bus.acc_o, exp);
        end
        take();
        issue('1);
        wait_done(n, bc);
        exp = exp_q.pop_front();
        cmp_cnt++;
        if (bus.out_valid_o !== 1'b1 || bus.acc_o !== exp) begin
            err_cnt++;
            $display("FAIL wr_ignored_after: valid=%b acc=%h required 1 %h", bus.out_valid_o, bus.acc_o, exp);
        end
        take();
    endtask

    task automatic test_write_accept();
        int n, bc;
        logic [ACT_W-1:0] a;
        logic [N_COLS-1:0] d;
        logic [ACCV-1:0] exp;
        a = rand_act();
        d = ~model_w[5];
        @(negedge clk);
        bus.wr_en_i    = 1'b1;
        bus.wr_row_i   = 6'd5;
        bus.wr_data_i  = d;
        bus.act_i      = a;
        bus.in_valid_i = 1'b1;
        model_w[5] = d;
        @(posedge clk);
        exp_q.push_back(ref_acc(a));
        @(negedge clk);
        bus.wr_en_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        wait_done(n, bc);
        exp = exp_q.pop_front();
        cmp_cnt++;
        if (bus.out_valid_o !== 1'b1 || bus.acc_o !== exp) begin
            err_cnt++;
            $display("FAIL wr_at_accept: valid=%b acc=%h required 1 %h", bus.out_valid_o, bus.acc_o, exp);
        end
        take();
    endtask

    task automatic test_random();
        int n, bc;
        logic [ACCV-1:0] exp;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) write_row($urandom_range(0, N_ROWS-1), rand_row());
            issue(rand_act());
            wait_done(n, bc);
            exp = exp_q.pop_front();
            cmp_cnt++;
            if (bus.out_valid_o !== 1'b1 || bus.acc_o !== exp) begin
                err_cnt++;
                $display("FAIL random_%0d: valid=%b acc=%h required 1 %h", t, bus.out_valid_o, bus.acc_o, exp);
            end
            take();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        for (int r = 0; r < N_ROWS; r++) model_w[r] = '0;
        bus.wr_en_i     = 1'b0;
        bus.wr_row_i    = '0;
        bus.wr_data_i   = '0;
        bus.in_valid_i  = 1'b0;
        bus.act_i       = '0;
        bus.out_ready_i = 1'b0;
        rst = 1'b1;

        test_reset();
        test_all_ones();
        test_sparse_col0();
        test_latency();
        test_backpressure();
        test_write_during_compute();
        test_write_accept();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
